spi_byte_sequencer: RTL

- Multi-byte transaction sequencer placed directly upstream of the byte-level SPI master.
- Accepts a command (byte count plus RX-capture flag), then pulls TX bytes from a valid/ready stream.
- For each byte it pulses the master's start, waits for its done, and optionally forwards the received byte on an RX valid/ready stream.
- Enforces a minimum inter-byte gap so the master is back in IDLE before each new start.

---
 rtl/spi_seq_pkg.sv | 23 ++
 rtl/spi_byte_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and default sizing for the SPI byte sequencer.
// State encoding plus parameter defaults; no logic.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DRAIN,
        GAP
    } state_t;

    localparam int DEF_LEN_W          = 8;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // A zero gap would let a start land while the master is still leaving DONE.
    function automatic int eff_gap(input int gap);
        return (gap < 1) ? 1 : gap;
    endfunction

endpackage

// File: rtl/spi_byte_sequencer.sv
// Sequences cmd_len bytes through a byte-level SPI master: fetch, start, wait done, forward RX.
// Latency: first spi_start 2 cycles after command accept with TX ready; done->next start >= GAP_CYCLES+3.
// Backpressure: stalls on tx_valid low or rx_ready low; SPI_SEQ_TIMEOUT_EN adds a done watchdog.
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int LEN_W          = DEF_LEN_W,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_rx_en,
    output logic             cmd_done,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             err,
    output logic             spi_start,
    output logic [7:0]       spi_tx,
    input  logic [7:0]       spi_rx,
    input  logic             spi_done
);

    localparam int GAP_EFF = eff_gap(GAP_CYCLES);
    localparam int GAP_W   = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             rx_en;
    logic [GAP_W-1:0] gap_cnt;
    logic             timeout;
    logic             drain_ok;

    // A held RX byte may be taken in the same cycle DRAIN looks at it.
    assign drain_ok = !rx_valid || rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        tx_ready  = 1'b0;
        spi_start = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid && (cmd_len != '0)) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                spi_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (spi_done) begin
                    state_nxt = DRAIN;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_nxt = (remaining == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            rx_en     <= 1'b0;
            spi_tx    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            cmd_done  <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            cmd_done <= 1'b0;
            if (cmd_ready && cmd_valid) begin
                remaining <= cmd_len;
                rx_en     <= cmd_rx_en;
                if (cmd_len == '0) begin
                    cmd_done <= 1'b1;
                end
            end
            if (tx_ready && tx_valid) begin
                spi_tx <= tx_data;
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if ((state == WAIT) && spi_done) begin
                if (remaining != '0) begin
                    remaining <= remaining - LEN_W'(1);
                end
                if (rx_en) begin
                    rx_data  <= spi_rx;
                    rx_valid <= 1'b1;
                end
            end
            if ((state == DRAIN) && drain_ok && (remaining == '0)) begin
                cmd_done <= 1'b1;
            end
            if (timeout && !spi_done) begin
                cmd_done <= 1'b1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Counter value k marks the (k+1)-th cycle spent in WAIT.
    assign timeout = (state == WAIT) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT) ? to_cnt + TO_W'(1) : '0;
            if (cmd_ready && cmd_valid) begin
                err <= 1'b0;
            end else if (timeout && !spi_done) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
